// File: rtl/sfm_pass_scheduler.sv
// sfm_pass_scheduler: sequences the two-pass softmax job (accumulate, then normalize)
// across the streamer requests, datapath mode/last/strobe and completion pulse.
module sfm_pass_scheduler #(
  parameter int DATA_WIDTH = 96,
  parameter int ELEM_WIDTH = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 32,
  localparam int VECT = DATA_WIDTH / ELEM_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [ADDR_WIDTH-1:0] in_addr_i,
  input  logic [ADDR_WIDTH-1:0] out_addr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  in_req_valid_o,
  input  logic                  in_req_ready_i,
  output logic [ADDR_WIDTH-1:0] in_req_addr_o,
  output logic [LEN_WIDTH-1:0]  in_req_len_o,
  output logic                  out_req_valid_o,
  input  logic                  out_req_ready_i,
  output logic [ADDR_WIDTH-1:0] out_req_addr_o,
  output logic [LEN_WIDTH-1:0]  out_req_len_o,
  input  logic                  in_beat_i,
  input  logic                  out_beat_i,
  output logic [1:0]            dp_mode_o,
  output logic                  dp_last_o,
  output logic [VECT-1:0]       dp_strb_o,
  input  logic                  dp_acc_done_i
);
  localparam logic [LEN_WIDTH-1:0] VECT_L = LEN_WIDTH'(VECT);
  typedef enum logic [2:0] {
    S_IDLE, S_ACC_REQ, S_ACC_RUN, S_ACC_WAIT, S_NORM_REQ, S_NORM_RUN, S_DONE
  } state_t;
  state_t r_state, w_next;
  logic [LEN_WIDTH-1:0]  r_len, r_in_rem, r_out_rem, w_in_step, w_out_step;
  logic [ADDR_WIDTH-1:0] r_in_addr, r_out_addr;
  logic r_in_acc, r_out_acc;
  logic w_in_fire, w_out_fire, w_in_last, w_out_last;
  assign w_in_fire  = in_req_valid_o & in_req_ready_i;
  assign w_out_fire = out_req_valid_o & out_req_ready_i;
  assign w_in_last  = r_in_rem <= VECT_L;
  assign w_out_last = r_out_rem <= VECT_L;
  assign w_in_step  = w_in_last ? r_in_rem : VECT_L;
  assign w_out_step = w_out_last ? r_out_rem : VECT_L;
  assign busy_o          = r_state != S_IDLE;
  assign done_o          = r_state == S_DONE;
  assign in_req_valid_o  = (r_state == S_ACC_REQ) | ((r_state == S_NORM_REQ) & ~r_in_acc);
  assign out_req_valid_o = (r_state == S_NORM_REQ) & ~r_out_acc;
  assign in_req_addr_o   = r_in_addr;
  assign in_req_len_o    = r_len;
  assign out_req_addr_o  = r_out_addr;
  assign out_req_len_o   = r_len;
  assign dp_mode_o = (r_state == S_ACC_RUN || r_state == S_ACC_WAIT) ? 2'd1 :
                     (r_state == S_NORM_RUN) ? 2'd2 : 2'd0;
  assign dp_last_o = w_in_last & (r_in_rem != '0) & (dp_mode_o != 2'd0);
  // Shifting by in_rem >= VECT clears every bit, so the inverse saturates to all ones.
  assign dp_strb_o = ~({VECT{1'b1}} << r_in_rem);
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (start_i) w_next = (len_i == '0) ? S_DONE : S_ACC_REQ;
      S_ACC_REQ:  if (in_req_ready_i) w_next = S_ACC_RUN;
      S_ACC_RUN:  if (in_beat_i && w_in_last) w_next = S_ACC_WAIT;
      S_ACC_WAIT: if (dp_acc_done_i) w_next = S_NORM_REQ;
      S_NORM_REQ: if ((r_in_acc | w_in_fire) && (r_out_acc | w_out_fire)) w_next = S_NORM_RUN;
      S_NORM_RUN: if (out_beat_i && w_out_last) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else r_state <= clear_i ? S_IDLE : w_next;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_len <= '0; r_in_addr <= '0; r_out_addr <= '0;
      r_in_rem <= '0; r_out_rem <= '0; r_in_acc <= 1'b0; r_out_acc <= 1'b0;
    end else if (clear_i) begin
      r_len <= '0; r_in_addr <= '0; r_out_addr <= '0;
      r_in_rem <= '0; r_out_rem <= '0; r_in_acc <= 1'b0; r_out_acc <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (start_i) begin
          r_len <= len_i; r_in_addr <= in_addr_i; r_out_addr <= out_addr_i; r_in_rem <= len_i;
        end
        S_ACC_RUN: if (in_beat_i) r_in_rem <= r_in_rem - w_in_step;
        S_ACC_WAIT: if (dp_acc_done_i) begin
          r_in_rem <= r_len; r_out_rem <= r_len; r_in_acc <= 1'b0; r_out_acc <= 1'b0;
        end
        S_NORM_REQ: begin
          if (w_in_fire) r_in_acc <= 1'b1;
          if (w_out_fire) r_out_acc <= 1'b1;
        end
        S_NORM_RUN: begin
          if (in_beat_i) r_in_rem <= r_in_rem - w_in_step;
          if (out_beat_i) r_out_rem <= r_out_rem - w_out_step;
        end
        S_DONE: begin
          r_in_rem <= '0; r_out_rem <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sfm_pass_scheduler.sv
// tb_sfm_pass_scheduler: directed vectors against hand-computed expectations.
module tb_sfm_pass_scheduler;
  logic        clk_i = 1'b0, rst_ni = 1'b0, clear_i = 1'b0, start_i = 1'b0;
  logic [31:0] len_i = '0, in_addr_i = '0, out_addr_i = '0;
  logic        busy_o, done_o, in_req_valid_o, out_req_valid_o;
  logic        in_req_ready_i = 1'b0, out_req_ready_i = 1'b0;
  logic [31:0] in_req_addr_o, in_req_len_o, out_req_addr_o, out_req_len_o;
  logic        in_beat_i = 1'b0, out_beat_i = 1'b0, dp_acc_done_i = 1'b0;
  logic [1:0]  dp_mode_o;
  logic        dp_last_o;
  logic [5:0]  dp_strb_o;
  int n_cmp = 0, n_err = 0;

  sfm_pass_scheduler dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .len_i(len_i), .in_addr_i(in_addr_i), .out_addr_i(out_addr_i),
    .busy_o(busy_o), .done_o(done_o),
    .in_req_valid_o(in_req_valid_o), .in_req_ready_i(in_req_ready_i),
    .in_req_addr_o(in_req_addr_o), .in_req_len_o(in_req_len_o),
    .out_req_valid_o(out_req_valid_o), .out_req_ready_i(out_req_ready_i),
    .out_req_addr_o(out_req_addr_o), .out_req_len_o(out_req_len_o),
    .in_beat_i(in_beat_i), .out_beat_i(out_beat_i),
    .dp_mode_o(dp_mode_o), .dp_last_o(dp_last_o), .dp_strb_o(dp_strb_o),
    .dp_acc_done_i(dp_acc_done_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are observed on the falling edge.
  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".busy"}, busy_o, 0);
    chk({tag, ".done"}, done_o, 0);
    chk({tag, ".in_v"}, in_req_valid_o, 0);
    chk({tag, ".out_v"}, out_req_valid_o, 0);
    chk({tag, ".mode"}, dp_mode_o, 0);
    chk({tag, ".last"}, dp_last_o, 0);
    chk({tag, ".strb"}, dp_strb_o, 0);
    chk({tag, ".in_addr"}, in_req_addr_o, 0);
    chk({tag, ".in_len"}, in_req_len_o, 0);
    chk({tag, ".out_addr"}, out_req_addr_o, 0);
    chk({tag, ".out_len"}, out_req_len_o, 0);
  endtask

  task automatic start(input logic [31:0] len, input logic [31:0] ia, input logic [31:0] oa);
    start_i = 1'b1; len_i = len; in_addr_i = ia; out_addr_i = oa;
    tick();
    start_i = 1'b0; len_i = '0; in_addr_i = '0; out_addr_i = '0;
  endtask

  initial begin
    #1 chk_reset_vals("rst");
    tick();
    rst_ni = 1'b1;
    in_req_ready_i = 1'b1; out_req_ready_i = 1'b1;

    // len=12, all readies high
    start(12, 32'h1000, 32'h2000);
    chk("t12.busy", busy_o, 1);
    chk("t12.acc_v", in_req_valid_o, 1);
    chk("t12.acc_addr", in_req_addr_o, 32'h1000);
    chk("t12.acc_len", in_req_len_o, 12);
    chk("t12.acc_outv", out_req_valid_o, 0);
    tick();
    chk("t12.run_mode", dp_mode_o, 1);
    chk("t12.run_v", in_req_valid_o, 0);
    chk("t12.b1_strb", dp_strb_o, 6'h3f);
    chk("t12.b1_last", dp_last_o, 0);
    in_beat_i = 1'b1; tick();
    chk("t12.b2_strb", dp_strb_o, 6'h3f);
    chk("t12.b2_last", dp_last_o, 1);
    tick(); in_beat_i = 1'b0;
    chk("t12.wait_mode", dp_mode_o, 1);
    chk("t12.wait_last", dp_last_o, 0);
    chk("t12.wait_strb", dp_strb_o, 0);
    tick();
    chk("t12.wait_hold", dp_mode_o, 1);
    dp_acc_done_i = 1'b1; tick(); dp_acc_done_i = 1'b0;
    chk("t12.nreq_inv", in_req_valid_o, 1);
    chk("t12.nreq_outv", out_req_valid_o, 1);
    chk("t12.nreq_inlen", in_req_len_o, 12);
    chk("t12.nreq_outlen", out_req_len_o, 12);
    chk("t12.nreq_outaddr", out_req_addr_o, 32'h2000);
    chk("t12.nreq_mode", dp_mode_o, 0);
    tick();
    chk("t12.nrun_mode", dp_mode_o, 2);
    chk("t12.nrun_inv", in_req_valid_o, 0);
    chk("t12.nrun_outv", out_req_valid_o, 0);
    in_beat_i = 1'b1; out_beat_i = 1'b1; tick();
    chk("t12.o1_done", done_o, 0);
    chk("t12.o1_last", dp_last_o, 1);
    tick(); in_beat_i = 1'b0; out_beat_i = 1'b0;
    chk("t12.done", done_o, 1);
    chk("t12.done_busy", busy_o, 1);
    tick();
    chk("t12.idle_done", done_o, 0);
    chk("t12.idle_busy", busy_o, 0);

    // len=7 with start pulses in ACC_RUN and ACC_WAIT that must be ignored
    start(7, 32'h3000, 32'h4000);
    tick();
    chk("t7.b1_strb", dp_strb_o, 6'h3f);
    chk("t7.b1_last", dp_last_o, 0);
    in_beat_i = 1'b1; start_i = 1'b1; len_i = 99; in_addr_i = 32'hdead; out_addr_i = 32'hbeef;
    tick(); start_i = 1'b0;
    chk("t7.b2_strb", dp_strb_o, 6'h01);
    chk("t7.b2_last", dp_last_o, 1);
    tick(); in_beat_i = 1'b0;
    chk("t7.wait_mode", dp_mode_o, 1);
    start_i = 1'b1; tick(); start_i = 1'b0;
    chk("t7.wait_keep", dp_mode_o, 1);
    chk("t7.wait_inaddr", in_req_addr_o, 32'h3000);
    dp_acc_done_i = 1'b1; tick(); dp_acc_done_i = 1'b0;
    len_i = '0; in_addr_i = '0; out_addr_i = '0;
    chk("t7.nreq_inlen", in_req_len_o, 7);
    chk("t7.nreq_inaddr", in_req_addr_o, 32'h3000);
    chk("t7.nreq_outaddr", out_req_addr_o, 32'h4000);
    chk("t7.nreq_outlen", out_req_len_o, 7);
    tick();
    out_beat_i = 1'b1; tick();
    chk("t7.o1_done", done_o, 0);
    chk("t7.o1_mode", dp_mode_o, 2);
    tick(); out_beat_i = 1'b0;
    chk("t7.done", done_o, 1);
    tick();
    chk("t7.idle", busy_o, 0);

    // len=0 goes straight to DONE
    start(0, 32'h1111, 32'h2222);
    chk("t0.done", done_o, 1);
    chk("t0.busy", busy_o, 1);
    chk("t0.in_v", in_req_valid_o, 0);
    chk("t0.out_v", out_req_valid_o, 0);
    tick();
    chk("t0.idle_busy", busy_o, 0);
    chk("t0.idle_done", done_o, 0);
    chk("t0.idle_inv", in_req_valid_o, 0);

    // request backpressure
    in_req_ready_i = 1'b0; out_req_ready_i = 1'b0;
    start(6, 32'h5000, 32'h6000);
    for (int i = 0; i < 5; i++) begin
      chk("bp.acc_v", in_req_valid_o, 1);
      chk("bp.acc_addr", in_req_addr_o, 32'h5000);
      chk("bp.acc_len", in_req_len_o, 6);
      tick();
    end
    chk("bp.acc_v_last", in_req_valid_o, 1);
    in_req_ready_i = 1'b1; tick(); in_req_ready_i = 1'b0;
    chk("bp.run_v", in_req_valid_o, 0);
    chk("bp.run_mode", dp_mode_o, 1);
    chk("bp.run_last", dp_last_o, 1);
    in_beat_i = 1'b1; tick(); in_beat_i = 1'b0;
    dp_acc_done_i = 1'b1; tick(); dp_acc_done_i = 1'b0;
    chk("bp.nreq_inv", in_req_valid_o, 1);
    chk("bp.nreq_outv", out_req_valid_o, 1);
    tick();
    chk("bp.nreq_hold_outv", out_req_valid_o, 1);
    chk("bp.nreq_hold_outaddr", out_req_addr_o, 32'h6000);
    out_req_ready_i = 1'b1; tick(); out_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp.wait_outv", out_req_valid_o, 0);
      chk("bp.wait_inv", in_req_valid_o, 1);
      chk("bp.wait_mode", dp_mode_o, 0);
      chk("bp.wait_inaddr", in_req_addr_o, 32'h5000);
      if (i == 2) in_req_ready_i = 1'b1;
      tick();
    end
    in_req_ready_i = 1'b0;
    chk("bp.nrun_mode", dp_mode_o, 2);
    chk("bp.nrun_inv", in_req_valid_o, 0);
    out_beat_i = 1'b1; tick(); out_beat_i = 1'b0;
    chk("bp.done", done_o, 1);
    tick();

    // clear in NORM_RUN after one out beat, then a fresh len=6 job
    in_req_ready_i = 1'b1; out_req_ready_i = 1'b1;
    start(12, 32'h7000, 32'h8000);
    tick();
    in_beat_i = 1'b1; tick(); tick(); in_beat_i = 1'b0;
    dp_acc_done_i = 1'b1; tick(); dp_acc_done_i = 1'b0;
    tick();
    chk("clr.pre_mode", dp_mode_o, 2);
    out_beat_i = 1'b1; tick(); out_beat_i = 1'b0;
    chk("clr.mid_busy", busy_o, 1);
    clear_i = 1'b1; out_beat_i = 1'b1; dp_acc_done_i = 1'b1; tick();
    clear_i = 1'b0; out_beat_i = 1'b0; dp_acc_done_i = 1'b0;
    chk_reset_vals("clr");
    tick();
    chk("clr.no_done", done_o, 0);
    start(6, 32'h9000, 32'ha000);
    chk("re.acc_len", in_req_len_o, 6);
    chk("re.acc_addr", in_req_addr_o, 32'h9000);
    tick();
    chk("re.strb", dp_strb_o, 6'h3f);
    chk("re.last", dp_last_o, 1);
    in_beat_i = 1'b1; tick(); in_beat_i = 1'b0;
    chk("re.wait_strb", dp_strb_o, 0);
    dp_acc_done_i = 1'b1; tick(); dp_acc_done_i = 1'b0;
    chk("re.nreq_outaddr", out_req_addr_o, 32'ha000);
    tick();
    in_beat_i = 1'b1; out_beat_i = 1'b1; tick(); in_beat_i = 1'b0; out_beat_i = 1'b0;
    chk("re.done", done_o, 1);
    tick();
    chk("re.idle", busy_o, 0);

    // asynchronous reset mid-job takes effect without a clock edge
    start(12, 32'hb000, 32'hc000);
    tick();
    #2 rst_ni = 1'b0;
    #1 chk_reset_vals("arst");
    tick();
    rst_ni = 1'b1;
    tick();
    chk("arst.stay_idle", busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
